// File: rtl/vctrl_pkg.sv
// Shared definitions for the vector control register write path:
// register indices, default widths and the buffered write entry.
package vctrl_pkg;

   localparam int DW_DEF    = 32;
   localparam int RW_DEF    = 5;
   localparam int MVL_DEF   = 32;
   localparam int MASKW_DEF = 8;

   localparam int VL_REG         = 0;
   localparam int MASK_BCOLS_REG = 29;
   localparam int MASK_ACOLS_REG = 30;
   localparam int MASK_AROWS_REG = 31;

   typedef struct packed {
      logic [RW_DEF-1:0] reg_idx;
      logic [DW_DEF-1:0] data;
   } vctrl_entry_t;

   function automatic logic is_mask_reg(input int idx);
      return (idx == MASK_BCOLS_REG) || (idx == MASK_ACOLS_REG) || (idx == MASK_AROWS_REG);
   endfunction

endpackage

// File: rtl/vctrl_wr_fifo.sv
// Small synchronous FIFO of control-register writes with flush and a
// tail-data overwrite port used for write coalescing.
module vctrl_wr_fifo
   import vctrl_pkg::*;
#(
   parameter int RW    = RW_DEF,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic                       overwrite,
   input  logic [RW-1:0]              push_reg,
   input  logic [DW-1:0]              push_data,
   output logic [RW-1:0]              head_reg,
   output logic [DW-1:0]              head_data,
   output logic [RW-1:0]              tail_reg,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int AW = $clog2(DEPTH);

   logic [RW-1:0]  reg_mem  [DEPTH];
   logic [DW-1:0]  data_mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic [AW-1:0]  tail_ptr;
   logic [DEPTH-1:0] alloc_sel;
   logic [DEPTH-1:0] ovw_sel;

   assign tail_ptr  = wr_ptr_reg - AW'(1);
   assign head_reg  = reg_mem[rd_ptr_reg];
   assign head_data = data_mem[rd_ptr_reg];
   assign tail_reg  = reg_mem[tail_ptr];
   assign full      = (count_reg == (AW+1)'(DEPTH));
   assign empty     = (count_reg == '0);
   assign occupancy = count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_sel
         assign alloc_sel[gi] = push && (wr_ptr_reg == AW'(gi));
         assign ovw_sel[gi]   = overwrite && (tail_ptr == AW'(gi));
      end
   endgenerate

   // Storage carries no reset; validity is defined purely by the pointers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc_sel[i]) begin
            reg_mem[i]  <= push_reg;
            data_mem[i] <= push_data;
         end else if (ovw_sel[i]) begin
            data_mem[i] <= push_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

endmodule

// File: rtl/vctrl_write_issuer.sv
// Buffers scalar control-register writes and issues one per cycle to the
// vector control register file. Optional coalescing: VCTRL_WR_COALESCE_EN.
module vctrl_write_issuer
   import vctrl_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int RW    = RW_DEF,
   parameter int MVL   = MVL_DEF,
   parameter int MASKW = MASKW_DEF,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [RW-1:0]           req_reg,
   input  logic [DW-1:0]           req_data,
   input  logic                    drain_stall,
   input  logic                    flush,
   output logic [RW-1:0]           c_reg,
   output logic [DW-1:0]           c_writedatain,
   output logic                    c_we,
   output logic                    rsp_valid,
   output logic [DW-1:0]           rsp_vl,
   output logic                    vl_pending,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int OW = $clog2(DEPTH) + 1;
`ifdef VCTRL_WR_COALESCE_EN
   localparam bit COALESCE = 1'b1;
`else
   localparam bit COALESCE = 1'b0;
`endif

   logic [RW-1:0] head_reg, tail_reg;
   logic [DW-1:0] head_data, shaped;
   logic          full, empty, pop_en, push_en, ovw_en, tail_hit, head_is_vl;
   logic [OW-1:0] occ;
   logic [OW-1:0] vl_cnt_reg;
   logic [RW-1:0] c_reg_reg;
   logic [DW-1:0] c_data_reg, rsp_vl_reg;
   logic          c_we_reg, rsp_valid_reg;

   assign pop_en = !empty && !drain_stall && !flush;
   // A tail that is also the head and is leaving this cycle cannot absorb a write.
   assign tail_hit  = COALESCE && !empty && (req_reg == tail_reg) && !(pop_en && (occ == OW'(1)));
   assign req_ready = !reset && !flush && (!full || tail_hit);
   assign push_en   = req_valid && req_ready && !tail_hit;
   assign ovw_en    = req_valid && req_ready && tail_hit;
   assign head_is_vl = (head_reg == RW'(VL_REG));

   vctrl_wr_fifo #(.RW(RW), .DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_en),
      .pop       (pop_en),
      .flush     (flush),
      .overwrite (ovw_en),
      .push_reg  (req_reg),
      .push_data (req_data),
      .head_reg  (head_reg),
      .head_data (head_data),
      .tail_reg  (tail_reg),
      .full      (full),
      .empty     (empty),
      .occupancy (occ)
   );

   always_comb begin
      shaped = head_data;
      if (head_is_vl)
         shaped = (head_data > DW'(MVL)) ? DW'(MVL) : head_data;
      else if (is_mask_reg(int'(head_reg)))
         shaped = DW'(head_data[MASKW-1:0]);
   end

   // Coalesced writes land on a tail with the same index, so they never change the vl count.
   always_ff @(posedge clk) begin
      if (reset || flush)
         vl_cnt_reg <= '0;
      else
         vl_cnt_reg <= vl_cnt_reg + OW'(push_en && (req_reg == RW'(VL_REG)))
                                  - OW'(pop_en && head_is_vl);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_we_reg      <= 1'b0;
         c_reg_reg     <= '0;
         c_data_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_vl_reg    <= '0;
      end else begin
         c_we_reg      <= pop_en;
         rsp_valid_reg <= pop_en && head_is_vl;
         if (pop_en) begin
            c_reg_reg  <= head_reg;
            c_data_reg <= shaped;
         end
         if (pop_en && head_is_vl)
            rsp_vl_reg <= shaped;
      end
   end

   assign c_we          = c_we_reg;
   assign c_reg         = c_reg_reg;
   assign c_writedatain = c_data_reg;
   assign rsp_valid     = rsp_valid_reg;
   assign rsp_vl        = rsp_vl_reg;
   assign occupancy     = occ;
   assign vl_pending    = (vl_cnt_reg != '0) || (c_we_reg && (c_reg_reg == RW'(VL_REG)));

endmodule

// File: tb/tb_vctrl_write_issuer.sv
// Scoreboard bench for vctrl_write_issuer: accepted writes are queued in a
// reference FIFO and compared against c_* when the DUT issues them.
module tb_vctrl_write_issuer;
   import vctrl_pkg::*;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_reg;
   logic [31:0] req_data;
   logic        drain_stall;
   logic        flush;
   logic [4:0]  c_reg;
   logic [31:0] c_writedatain;
   logic        c_we;
   logic        rsp_valid;
   logic [31:0] rsp_vl;
   logic        vl_pending;
   logic [2:0]  occupancy;

   vctrl_write_issuer #(.DW(32), .RW(5), .MVL(32), .MASKW(8), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_reg       (req_reg),
      .req_data      (req_data),
      .drain_stall   (drain_stall),
      .flush         (flush),
      .c_reg         (c_reg),
      .c_writedatain (c_writedatain),
      .c_we          (c_we),
      .rsp_valid     (rsp_valid),
      .rsp_vl        (rsp_vl),
      .vl_pending    (vl_pending),
      .occupancy     (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vctrl_entry_t model_q[$];
   bit           last_issue;
   logic [4:0]   last_reg;
   bit           last_accepted;
   int           n_checks;
   int           n_fail;
   int           cyc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] shape(input vctrl_entry_t e);
      if (e.reg_idx == 5'd0)
         return (e.data > 32'd32) ? 32'd32 : e.data;
      if (e.reg_idx >= 5'd29)
         return {24'd0, e.data[7:0]};
      return e.data;
   endfunction

   function automatic bit vl_buffered();
      foreach (model_q[i])
         if (model_q[i].reg_idx == 5'd0) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: predict ready/pop from the reference queue, step it, then compare.
   task automatic cycle();
      bit pop_now, hit, rdy, acc;
      vctrl_entry_t head, in_e;
      #1;
      head = '0;
      pop_now = !reset && (model_q.size() > 0) && !drain_stall && !flush;
      hit = 1'b0;
`ifdef VCTRL_WR_COALESCE_EN
      hit = (model_q.size() > 0) && (model_q[$].reg_idx == req_reg) && !(pop_now && model_q.size() == 1);
`endif
      rdy = !reset && !flush && ((model_q.size() < DEPTH) || hit);
      check("req_ready", 64'(req_ready), 64'(rdy));
      acc = req_valid && rdy;
      last_accepted = acc;
      in_e.reg_idx = req_reg;
      in_e.data    = req_data;
      if (reset) begin
         model_q.delete();
      end else begin
         if (pop_now) head = model_q.pop_front();
         if (flush) model_q.delete();
         else if (acc) begin
            if (hit) model_q[$].data = req_data;
            else model_q.push_back(in_e);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      last_issue = pop_now;
      last_reg   = head.reg_idx;
      check("c_we", 64'(c_we), 64'(pop_now));
      check("rsp_valid", 64'(rsp_valid), 64'(pop_now && head.reg_idx == 5'd0));
      if (pop_now) begin
         check("c_reg", 64'(c_reg), 64'(head.reg_idx));
         check("c_writedatain", 64'(c_writedatain), 64'(shape(head)));
         if (head.reg_idx == 5'd0) check("rsp_vl", 64'(rsp_vl), 64'(shape(head)));
      end
      check("occupancy", 64'(occupancy), 64'(model_q.size()));
      check("vl_pending", 64'(vl_pending), 64'(vl_buffered() || (last_issue && last_reg == 5'd0)));
      if (acc || pop_now || reset || flush)
         $display("cyc %0d rst=%0b flush=%0b push=%0b reg=%0d data=%0h | issue=%0b c_reg=%0d c_data=%0h occ=%0d",
                  cyc, reset, flush, acc, req_reg, req_data, pop_now, c_reg, c_writedatain, occupancy);
   endtask

   task automatic push_wait(input logic [4:0] r, input logic [31:0] d, input int budget);
      int n;
      req_valid = 1'b1;
      req_reg   = r;
      req_data  = d;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!last_accepted && n < budget);
      if (!last_accepted) check("push_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) cycle();
   endtask

   initial begin
      logic [4:0] regs [6];
      regs = '{5'd0, 5'd1, 5'd29, 5'd30, 5'd31, 5'd7};
      n_checks = 0; n_fail = 0; cyc = 0;
      last_issue = 1'b0; last_reg = '0; last_accepted = 1'b0;
      reset = 1'b1; req_valid = 1'b0; req_reg = '0; req_data = '0;
      drain_stall = 1'b0; flush = 1'b0;

      repeat (2) cycle();
      check("rst_c_reg", 64'(c_reg), 64'd0);
      check("rst_c_data", 64'(c_writedatain), 64'd0);
      check("rst_rsp_vl", 64'(rsp_vl), 64'd0);
      reset = 1'b0;
      idle(1);

      // Basic vl write, clamping and mask shaping
      push_wait(5'd0, 32'd20, 4);
      check("vl_pending_accept", 64'(vl_pending), 64'd1);
      idle(2);
      push_wait(5'd0, 32'd100, 4);
      push_wait(5'd31, 32'h1234, 4);
      push_wait(5'd5, 32'hdead_beef, 4);
      idle(3);

      // Full FIFO under stall, then release
      drain_stall = 1'b1;
      for (int i = 0; i < 4; i++) push_wait(5'(i + 1), 32'(16 * i + 3), 2);
      req_valid = 1'b1; req_reg = 5'd9; req_data = 32'h99;
      repeat (3) cycle();
      check("full_occ", 64'(occupancy), 64'd4);
      drain_stall = 1'b0;
      push_wait(5'd9, 32'h99, 6);
      idle(6);

      // Flush with a pending push while buffered
      drain_stall = 1'b1;
      push_wait(5'd0, 32'd9, 2);
      push_wait(5'd3, 32'd33, 2);
      push_wait(5'd4, 32'd44, 2);
      flush = 1'b1; req_valid = 1'b1; req_reg = 5'd5; req_data = 32'h55;
      cycle();
      flush = 1'b0; req_valid = 1'b0; drain_stall = 1'b0;
      idle(3);

      // Flush while a vl write sits on c_*
      push_wait(5'd0, 32'd7, 2);
      push_wait(5'd2, 32'd22, 2);
      flush = 1'b1; req_valid = 1'b1; req_reg = 5'd6; req_data = 32'h66;
      cycle();
      flush = 1'b0; req_valid = 1'b0;
      idle(2);

      // Reset with two buffered and one issuing
      drain_stall = 1'b1;
      push_wait(5'd0, 32'd11, 2);
      push_wait(5'd2, 32'd12, 2);
      drain_stall = 1'b0;
      push_wait(5'd3, 32'd13, 2);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      idle(2);

`ifdef VCTRL_WR_COALESCE_EN
      drain_stall = 1'b1;
      push_wait(5'd30, 32'd3, 2);
      push_wait(5'd30, 32'd7, 2);
      check("coalesce_occ", 64'(occupancy), 64'd1);
      drain_stall = 1'b0;
      idle(3);
`endif

      // Randomised traffic
      for (int i = 0; i < 60; i++) begin
         req_valid   = 1'($urandom_range(0, 1));
         req_reg     = regs[$urandom_range(0, 5)];
         req_data    = $urandom;
         drain_stall = ($urandom_range(0, 3) == 0);
         flush       = ($urandom_range(0, 15) == 0);
         cycle();
      end
      flush = 1'b0; drain_stall = 1'b0;
      idle(8);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
